// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM.
// MC_CTRL_ADDI_EN adds the ADDI_EX/ADDI_WB states to the encoding.
package mc_ctrl_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_R_EXEC   = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_TRAP     = 4'd10;
`ifdef MC_CTRL_ADDI_EN
    localparam logic [3:0] S_ADDI_EX  = 4'd11;
    localparam logic [3:0] S_ADDI_WB  = 4'd12;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUB_RT     = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore decoder: current FSM state -> raw datapath control bundle.
// MC_CTRL_ADDI_EN adds the ADDI execute/write-back decodes.
import mc_ctrl_pkg::*;

module mc_ctrl_decode (
    input  logic [3:0] i_state,
    output ctrl_t      o_ctrl
);

    ctrl_t w_ctrl;

    always_comb begin
        w_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                w_ctrl.memread  = 1'b1;
                w_ctrl.irwrite  = 1'b1;
                w_ctrl.pcwrite  = 1'b1;
                w_ctrl.alusrcb  = ALUB_FOUR;
                w_ctrl.aluop    = ALUOP_ADD;
                w_ctrl.pcsource = PCS_ALU;
            end
            S_DECODE: begin
                w_ctrl.alusrcb = ALUB_IMM_SH;
                w_ctrl.aluop   = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = ALUB_IMM;
                w_ctrl.aluop   = ALUOP_ADD;
            end
            S_MEM_RD: begin
                w_ctrl.memread = 1'b1;
                w_ctrl.iord    = 1'b1;
            end
            S_MEM_WB: begin
                w_ctrl.memtoreg = 1'b1;
                w_ctrl.regwrite = 1'b1;
            end
            S_MEM_WR: begin
                w_ctrl.memwrite = 1'b1;
                w_ctrl.iord     = 1'b1;
            end
            S_R_EXEC: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = ALUB_RT;
                w_ctrl.aluop   = ALUOP_FUNCT;
            end
            S_R_WB: begin
                w_ctrl.regdst   = 1'b1;
                w_ctrl.regwrite = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl.alusrca     = 1'b1;
                w_ctrl.alusrcb     = ALUB_RT;
                w_ctrl.aluop       = ALUOP_SUB;
                w_ctrl.pcsource    = PCS_ALUOUT;
                w_ctrl.pcwritecond = 1'b1;
            end
            S_JUMP: begin
                w_ctrl.pcsource = PCS_JUMP;
                w_ctrl.pcwrite  = 1'b1;
            end
            S_TRAP: w_ctrl.illegal_op = 1'b1;
`ifdef MC_CTRL_ADDI_EN
            S_ADDI_EX: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = ALUB_IMM;
                w_ctrl.aluop   = ALUOP_ADD;
            end
            S_ADDI_WB: w_ctrl.regwrite = 1'b1;
`endif
            default: w_ctrl = '0;
        endcase
    end

    assign o_ctrl = w_ctrl;

endmodule

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM: state register, sequencing, gating.
// Define MC_CTRL_ADDI_EN to execute addi instead of trapping on it.
import mc_ctrl_pkg::*;

module mc_main_control #(
    parameter logic [3:0] RESET_STATE = S_FETCH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsource,
    output logic       illegal_op,
    output logic [3:0] state
);

    logic [3:0] r_state;
    logic       r_is_sw;
    logic [3:0] w_next;
    logic       w_fetch_wait;
    logic       w_on;
    ctrl_t      w_ctrl;

    mc_ctrl_decode u_decode (
        .i_state (r_state),
        .o_ctrl  (w_ctrl)
    );

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     w_next = S_R_EXEC;
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      w_next = S_ADDI_EX;
`endif
                    default:      w_next = S_TRAP;
                endcase
            end
            S_MEM_ADDR: w_next = r_is_sw ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   w_next = mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EXEC:   w_next = S_R_WB;
`ifdef MC_CTRL_ADDI_EN
            S_ADDI_EX:  w_next = S_ADDI_WB;
`endif
            default:    w_next = S_FETCH;
        endcase
    end

    // lw/sw is resolved in DECODE so opcode is never looked at again
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RESET_STATE;
            r_is_sw <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_is_sw <= (opcode == OP_SW);
        end
    end

    assign w_on         = ~rst;
    assign w_fetch_wait = (r_state == S_FETCH) & ~mem_ready;

    assign pcwrite     = w_on & w_ctrl.pcwrite & ~w_fetch_wait;
    assign irwrite     = w_on & w_ctrl.irwrite & ~w_fetch_wait;
    assign pcwritecond = w_on & w_ctrl.pcwritecond;
    assign iord        = w_on & w_ctrl.iord;
    assign memread     = w_on & w_ctrl.memread;
    assign memwrite    = w_on & w_ctrl.memwrite;
    assign memtoreg    = w_on & w_ctrl.memtoreg;
    assign regdst      = w_on & w_ctrl.regdst;
    assign regwrite    = w_on & w_ctrl.regwrite;
    assign alusrca     = w_on & w_ctrl.alusrca;
    assign alusrcb     = w_on ? w_ctrl.alusrcb : 2'b00;
    assign aluop       = w_on ? w_ctrl.aluop : 2'b00;
    assign pcsource    = w_on ? w_ctrl.pcsource : 2'b00;
    assign illegal_op  = w_on & w_ctrl.illegal_op;
    assign state       = w_on ? r_state : 4'd0;

endmodule

// File: tb/tb_mc_main_control.sv
// Scoreboard bench for mc_main_control: per-cycle expected outputs.
// Expected ADDI behaviour follows MC_CTRL_ADDI_EN.
module tb_mc_main_control;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b1;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, alusrca, illegal_op;
    logic [1:0] alusrcb, aluop, pcsource;
    logic [3:0] state;

    mc_main_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
        .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
        .pcsource(pcsource), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [20:0] v;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // field order: pcw pcwc iord mrd mwr irw m2r rdst rw asa | asb | aop | pcs | ill
    function automatic logic [20:0] exp_vec(input logic [3:0] st,
                                            input logic mr,
                                            input logic r);
        logic [16:0] c;
        if (r) return '0;
        case (st)
            S_FETCH:    c = {mr, 3'b001, 1'b0, mr, 4'b0000, 7'b01_00_00_0};
            S_DECODE:   c = 17'b0000000000_11_00_00_0;
            S_MEM_ADDR: c = 17'b0000000001_10_00_00_0;
            S_MEM_RD:   c = 17'b0011000000_00_00_00_0;
            S_MEM_WB:   c = 17'b0000001010_00_00_00_0;
            S_MEM_WR:   c = 17'b0010100000_00_00_00_0;
            S_R_EXEC:   c = 17'b0000000001_00_10_00_0;
            S_R_WB:     c = 17'b0000000110_00_00_00_0;
            S_BRANCH:   c = 17'b0100000001_00_01_01_0;
            S_JUMP:     c = 17'b1000000000_00_00_10_0;
            S_TRAP:     c = 17'b0000000000_00_00_00_1;
`ifdef MC_CTRL_ADDI_EN
            S_ADDI_EX:  c = 17'b0000000001_10_00_00_0;
            S_ADDI_WB:  c = 17'b0000000010_00_00_00_0;
`endif
            default:    c = '0;
        endcase
        return {st, c};
    endfunction

    task automatic cyc(input logic r, input logic mr, input logic [5:0] op,
                       input logic [3:0] st, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        mem_ready = mr;
        opcode = op;
        e.v = exp_vec(st, mr, r);
        e.tag = tag;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [20:0] act;
            e = q.pop_front();
            act = {state, pcwrite, pcwritecond, iord, memread, memwrite,
                   irwrite, memtoreg, regdst, regwrite, alusrca,
                   alusrcb, aluop, pcsource, illegal_op};
            n_chk++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b required %b", e.tag, act, e.v);
            end
        end
    end

    initial begin
        cyc(1, 1, OP_RTYPE, S_FETCH, "reset0");
        cyc(1, 1, OP_RTYPE, S_FETCH, "reset1");

        // R-type; mem_ready low outside memory states must be ignored
        cyc(0, 1, OP_RTYPE, S_FETCH, "r_fetch");
        cyc(0, 0, OP_RTYPE, S_DECODE, "r_decode");
        cyc(0, 0, OP_RTYPE, S_R_EXEC, "r_exec");
        cyc(0, 1, OP_RTYPE, S_R_WB, "r_wb");

        // lw with 2 fetch stalls and 3 read stalls: 10 cycles
        cyc(0, 0, OP_LW, S_FETCH, "lw_fetch_stall");
        cyc(0, 0, OP_LW, S_FETCH, "lw_fetch_stall");
        cyc(0, 1, OP_LW, S_FETCH, "lw_fetch");
        cyc(0, 1, OP_LW, S_DECODE, "lw_decode");
        cyc(0, 1, OP_LW, S_MEM_ADDR, "lw_addr");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, OP_LW, S_MEM_RD, "lw_rd_stall");
        cyc(0, 1, OP_LW, S_MEM_RD, "lw_rd");
        cyc(0, 1, OP_LW, S_MEM_WB, "lw_wb");

        // sw; opcode flips to lw after DECODE and must be ignored
        cyc(0, 1, OP_SW, S_FETCH, "sw_fetch");
        cyc(0, 1, OP_SW, S_DECODE, "sw_decode");
        cyc(0, 1, OP_LW, S_MEM_ADDR, "sw_addr");
        cyc(0, 1, OP_LW, S_MEM_WR, "sw_wr");

        // sw with one write stall
        cyc(0, 1, OP_SW, S_FETCH, "sw2_fetch");
        cyc(0, 1, OP_SW, S_DECODE, "sw2_decode");
        cyc(0, 1, OP_SW, S_MEM_ADDR, "sw2_addr");
        cyc(0, 0, OP_SW, S_MEM_WR, "sw2_wr_stall");
        cyc(0, 1, OP_SW, S_MEM_WR, "sw2_wr");

        cyc(0, 1, OP_BEQ, S_FETCH, "beq_fetch");
        cyc(0, 1, OP_BEQ, S_DECODE, "beq_decode");
        cyc(0, 1, OP_BEQ, S_BRANCH, "beq_branch");

        cyc(0, 1, OP_J, S_FETCH, "j_fetch");
        cyc(0, 1, OP_J, S_DECODE, "j_decode");
        cyc(0, 1, OP_J, S_JUMP, "j_jump");

        cyc(0, 1, 6'b111111, S_FETCH, "ill_fetch");
        cyc(0, 1, 6'b111111, S_DECODE, "ill_decode");
        cyc(0, 1, 6'b111111, S_TRAP, "ill_trap");

        cyc(0, 1, OP_ADDI, S_FETCH, "addi_fetch");
        cyc(0, 1, OP_ADDI, S_DECODE, "addi_decode");
`ifdef MC_CTRL_ADDI_EN
        cyc(0, 1, OP_ADDI, S_ADDI_EX, "addi_ex");
        cyc(0, 1, OP_ADDI, S_ADDI_WB, "addi_wb");
`else
        cyc(0, 1, OP_ADDI, S_TRAP, "addi_trap");
`endif

        // reset for 3 cycles while lw waits in MEM_RD
        cyc(0, 1, OP_LW, S_FETCH, "rlw_fetch");
        cyc(0, 1, OP_LW, S_DECODE, "rlw_decode");
        cyc(0, 1, OP_LW, S_MEM_ADDR, "rlw_addr");
        cyc(0, 0, OP_LW, S_MEM_RD, "rlw_rd_stall");
        for (int i = 0; i < 3; i++)
            cyc(1, 1, OP_LW, S_FETCH, "rlw_in_reset");
        cyc(0, 1, OP_RTYPE, S_FETCH, "post_rst_fetch");
        cyc(0, 1, OP_RTYPE, S_DECODE, "post_rst_decode");
        cyc(0, 1, OP_RTYPE, S_R_EXEC, "post_rst_exec");
        cyc(0, 1, OP_RTYPE, S_R_WB, "post_rst_wb");
        cyc(0, 0, OP_RTYPE, S_FETCH, "final_fetch");

        @(negedge clk);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_main_control.md
# mc_main_control

Multi-cycle main control FSM for the MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back steps, driving the datapath mux selects and write strobes. Produces the 2-bit ALU operation class consumed by the ALU control decoder. Stalls on a memory ready handshake.

## Interface
Parameters:
- RESET_STATE, FETCH (4'd0): state loaded by reset.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous reset, active-high
- opcode  in  6  instruction register bits [31:26]; sampled in DECODE
- mem_ready  in  1  memory completes the current access this cycle
- pcwrite  out  1  unconditional PC load
- pcwritecond  out  1  PC load if ALU zero (beq)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- irwrite  out  1  instruction register load
- memtoreg  out  1  register write data: 0 = ALUOut, 1 = MDR
- regdst  out  1  destination: 0 = rt, 1 = rd
- regwrite  out  1  register file write strobe
- alusrca  out  1  ALU A: 0 = PC, 1 = rs
- alusrcb  out  2  ALU B: 00 rt, 01 const 4, 10 signext imm, 11 signext imm<<2
- aluop  out  2  00 add, 01 subtract, 10 use funct
- pcsource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- state  out  4  current state, for debug

## Operation
States (Moore outputs; unlisted outputs 0):
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00. Hold until mem_ready=1; irwrite and pcwrite asserted only in the cycle mem_ready=1 (gated by mem_ready). -> DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Branch on opcode: 000000 -> R_EXEC; 100011/101011 -> MEM_ADDR; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDI_EX (macro only); else -> TRAP.
- MEM_ADDR: alusrca=1, alusrcb=10, aluop=00. lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: memread=1, iord=1; hold until mem_ready -> MEM_WB.
- MEM_WB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEM_WR: memwrite=1, iord=1; hold until mem_ready -> FETCH.
- R_EXEC: alusrca=1, alusrcb=00, aluop=10 -> R_WB.
- R_WB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsource=01, pcwritecond=1 -> FETCH.
- JUMP: pcsource=10, pcwrite=1 -> FETCH.
- TRAP: illegal_op=1 -> FETCH. Instruction discarded; no register or memory write.
- aluop never 11.
- memread/memwrite remain asserted, address stable, for every stall cycle.

## Timing
- Reset: while rst=1 every output is 0 (strobes gated) and state loads FETCH; first cycle after rst falls is FETCH.
- rst mid-instruction: aborts at the next edge; no write strobe in any cycle where rst=1.
- Cycles with mem_ready tied 1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 3.
- Each cycle mem_ready=0 in FETCH/MEM_RD/MEM_WR adds exactly one cycle.
- mem_ready outside those states is ignored.
- opcode sampled only in DECODE; changes elsewhere are ignored.

## Configuration
- MC_CTRL_ADDI_EN defined: opcode 001000 supported. ADDI_EX: alusrca=1, alusrcb=10, aluop=00 -> ADDI_WB. ADDI_WB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
- Undefined: 001000 goes to TRAP; ADDI states absent from the encoding.

## Structure
- Package mc_ctrl_pkg: state encoding constants, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), aluop constants, alusrcb/pcsource select constants.
- Sub-module mc_ctrl_decode: combinational state -> control-output decoder. Top holds the state register, next-state logic, mem_ready gating and reset gating.

## Test plan
- rst=1 for 3 cycles mid-lw (state MEM_RD) -> all outputs 0 during reset, state=FETCH one cycle after release, no regwrite.
- R-type (000000), mem_ready=1 -> states FETCH,DECODE,R_EXEC,R_WB; aluop=10 in R_EXEC, regdst=1 and regwrite=1 in R_WB, 4 cycles total.
- lw (100011) with mem_ready low 2 cycles in FETCH and 3 in MEM_RD -> 10 cycles; irwrite/pcwrite exactly one cycle; memtoreg=1, regwrite=1 in MEM_WB.
- sw (101011), mem_ready=1 -> memwrite=1, iord=1 for one cycle; regwrite never asserted; 4 cycles.
- beq then j -> BRANCH: aluop=01, pcsource=01, pcwritecond=1; JUMP: pcsource=10, pcwrite=1; 3 cycles each.
- opcode 111111, and 001000 with MC_CTRL_ADDI_EN undefined -> TRAP, illegal_op=1 one cycle, back to FETCH; with macro, 001000 -> ADDI_EX, ADDI_WB, regwrite=1, regdst=0.
